morse_key_decoder: RTL and testbench

Receive-side counterpart of the PS/2-to-Morse encoder. It takes a raw Morse straight-key input, debounces it, and measures mark and space durations against a fixed unit time. From those it decodes dots, dashes, character gaps and word gaps into ASCII characters, and delivers them one at a time over a valid/ready output register. It sits in the Tiny Tapeout top level between a `ui_in` pin and downstream character consumers (PS/2 device transmitter, display, UART).

---
 rtl/morse_pkg.sv | 8 +
 rtl/morse_lut.sv | 50 +++++
 rtl/morse_key_decoder.sv | 107 ++++++++++
 tb/tb_morse_key_decoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM state type and constants for the Morse key decoder
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD} morse_state_e;
  localparam int MORSE_CODE_W = 7;
  localparam int MORSE_MAX_SYM = 6;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: sentinel-prefixed Morse code (dot=0, dash=1) to ASCII, A-Z and 0-9
module morse_lut
  import morse_pkg::*;
(
  input  logic [MORSE_CODE_W-1:0] code,
  output logic [7:0]              ascii
);
  always_comb begin
    ascii = ASCII_UNKNOWN;
    case (code)
      7'd5:  ascii = 8'h41;
      7'd24: ascii = 8'h42;
      7'd26: ascii = 8'h43;
      7'd12: ascii = 8'h44;
      7'd2:  ascii = 8'h45;
      7'd18: ascii = 8'h46;
      7'd14: ascii = 8'h47;
      7'd16: ascii = 8'h48;
      7'd4:  ascii = 8'h49;
      7'd23: ascii = 8'h4A;
      7'd13: ascii = 8'h4B;
      7'd20: ascii = 8'h4C;
      7'd7:  ascii = 8'h4D;
      7'd6:  ascii = 8'h4E;
      7'd15: ascii = 8'h4F;
      7'd22: ascii = 8'h50;
      7'd29: ascii = 8'h51;
      7'd10: ascii = 8'h52;
      7'd8:  ascii = 8'h53;
      7'd3:  ascii = 8'h54;
      7'd9:  ascii = 8'h55;
      7'd17: ascii = 8'h56;
      7'd11: ascii = 8'h57;
      7'd25: ascii = 8'h58;
      7'd27: ascii = 8'h59;
      7'd28: ascii = 8'h5A;
      7'd63: ascii = 8'h30;
      7'd47: ascii = 8'h31;
      7'd39: ascii = 8'h32;
      7'd35: ascii = 8'h33;
      7'd33: ascii = 8'h34;
      7'd32: ascii = 8'h35;
      7'd48: ascii = 8'h36;
      7'd56: ascii = 8'h37;
      7'd60: ascii = 8'h38;
      7'd62: ascii = 8'h39;
      default: ascii = ASCII_UNKNOWN;
    endcase
  end
endmodule

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: debounced straight key to ASCII chars over valid/ready; MORSE_DEC_WORDSPACE_EN adds a space per word
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 10_000
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       key_in,
  output logic       key_db_o,
  output logic [7:0] char_o,
  output logic       char_valid_o,
  input  logic       char_ready_i,
  output logic       overrun_o
);
  localparam int CW = $clog2(5 * UNIT_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TWO_U = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] FIVE_U = CW'(5 * UNIT_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, db_flip, db_rise, db_fall;
  logic [DW-1:0] db_cnt;
  logic [CW-1:0] cnt;
  logic [MORSE_CODE_W-1:0] code;
  logic bad, sym_push, chr_done, spc_done, done, load;
  logic [7:0] lut_char, done_char;
  morse_state_e state, state_nxt;
  assign db_flip = (sync2 != key_db_o) && (db_cnt == DB_LAST);
  assign db_rise = db_flip & sync2;
  assign db_fall = db_flip & ~sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      key_db_o <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      key_db_o <= db_flip ? sync2 : key_db_o;
      db_cnt <= (sync2 == key_db_o || db_flip) ? '0 : db_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (!ena || db_flip) cnt <= '0;
    else if (cnt != FIVE_U) cnt <= cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (!ena) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = db_rise ? MARK : IDLE;
        MARK:    state_nxt = db_fall ? GAP : MARK;
        GAP:     state_nxt = db_rise ? MARK : (cnt == TWO_U) ? WORD : GAP;
        WORD:    state_nxt = db_rise ? MARK : (cnt == FIVE_U) ? IDLE : WORD;
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_comb begin
    sym_push = ena && state == MARK && db_fall;
    chr_done = ena && state == GAP && cnt == TWO_U;
`ifdef MORSE_DEC_WORDSPACE_EN
    spc_done = ena && state == WORD && !db_rise && cnt == FIVE_U;
`else
    spc_done = 1'b0;
`endif
    done = chr_done | spc_done;
    done_char = spc_done ? ASCII_SPACE : bad ? ASCII_UNKNOWN : lut_char;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= MORSE_CODE_W'(1);
      bad <= 1'b0;
    end else if (!ena || chr_done) begin
      code <= MORSE_CODE_W'(1);
      bad <= 1'b0;
    end else if (sym_push) begin
      code <= code[MORSE_MAX_SYM] ? code : {code[MORSE_CODE_W-2:0], cnt >= TWO_U};
      bad <= bad | code[MORSE_MAX_SYM];
    end
  end
  morse_lut u_lut (
    .code  (code),
    .ascii (lut_char)
  );
  assign load = done & (~char_valid_o | char_ready_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_o <= 8'h00;
      char_valid_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      char_o <= load ? done_char : char_o;
      char_valid_o <= load | (char_valid_o & ~char_ready_i);
      overrun_o <= done & ~load;
    end
  end
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: scoreboard bench, U=10 and DEBOUNCE_CYCLES=2
module tb_morse_key_decoder;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, key_in = 1'b0, char_ready_i = 1'b1;
  logic key_db_o, char_valid_o, overrun_o;
  logic [7:0] char_o;
  int cyc = 0, checks = 0, errors = 0, ovr_cnt = 0, ovr_base = 0;
  typedef struct { logic [7:0] ch; int t; } exp_t;
  exp_t q[$];
  exp_t e;
  morse_key_decoder #(.UNIT_CYCLES(10), .DEBOUNCE_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .key_in       (key_in),
    .key_db_o     (key_db_o),
    .char_o       (char_o),
    .char_valid_o (char_valid_o),
    .char_ready_i (char_ready_i),
    .overrun_o    (overrun_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (overrun_o) ovr_cnt++;
    if (rst_n && char_valid_o && char_ready_i) begin
      if (q.size() == 0) check("unexpected_char", char_o, 0);
      else begin
        e = q.pop_front();
        check("char_value", char_o, e.ch);
        if (e.t != 0) check("char_time", cyc, e.t);
      end
    end
  end
  // Key-in changes at cycle P reach key_db_o at P+4; a character lands at fall+25, a space at fall+55
  task automatic send(input string s, input logic [7:0] ch);
    int fall;
    int len;
    fall = 0;
    for (int i = 0; i < s.len(); i++) begin
      len = (s[i] == 8'h2D) ? 30 : 10;
      key_in = 1'b1;
      if (i == 0) begin
        repeat (3) tick();
        check("db_latency_lo", key_db_o, 0);
        tick();
        check("db_latency_hi", key_db_o, 1);
        repeat (len - 4) tick();
      end else repeat (len) tick();
      key_in = 1'b0;
      fall = cyc;
      if (i < s.len() - 1) repeat (10) tick();
    end
    q.push_back('{ch, fall + 25});
`ifdef MORSE_DEC_WORDSPACE_EN
    q.push_back('{8'h20, fall + 55});
`endif
    repeat (80) tick();
  endtask
  initial begin
    repeat (3) tick();
    check("reset_key_db", key_db_o, 0);
    check("reset_char", char_o, 0);
    check("reset_valid", char_valid_o, 0);
    check("reset_overrun", overrun_o, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    send(".", 8'h45);
    send("-.-", 8'h4B);
    send("-", 8'h54);
    send(".......", 8'h3F);
    send(".-", 8'h41);
    send("-----", 8'h30);
    char_ready_i = 1'b0;
    ovr_base = ovr_cnt;
    key_in = 1'b1;
    repeat (10) tick();
    key_in = 1'b0;
    repeat (30) tick();
    key_in = 1'b1;
    repeat (30) tick();
    key_in = 1'b0;
    repeat (80) tick();
    check("ovr_held_valid", char_valid_o, 1);
    check("ovr_held_char", char_o, 8'h45);
`ifdef MORSE_DEC_WORDSPACE_EN
    check("ovr_pulses", ovr_cnt - ovr_base, 2);
`else
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
`endif
    q.push_back('{8'h45, 0});
    char_ready_i = 1'b1;
    tick();
    check("ovr_drain_valid", char_valid_o, 0);
    repeat (20) tick();
    key_in = 1'b1;
    repeat (15) tick();
    ena = 1'b0;
    repeat (2) tick();
    ena = 1'b1;
    repeat (13) tick();
    key_in = 1'b0;
    repeat (80) tick();
    send("-", 8'h54);
    char_ready_i = 1'b0;
    key_in = 1'b1;
    repeat (10) tick();
    key_in = 1'b0;
    repeat (30) tick();
    key_in = 1'b1;
    repeat (8) tick();
    check("pre_rst_valid", char_valid_o, 1);
    check("pre_rst_key_db", key_db_o, 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_key_db", key_db_o, 0);
    check("async_rst_char", char_o, 0);
    check("async_rst_valid", char_valid_o, 0);
    check("async_rst_overrun", overrun_o, 0);
    key_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    char_ready_i = 1'b1;
    repeat (100) tick();
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
